// File: rtl/weight_skew_fifo_array.sv
// weight_skew_fifo_array: a bank of per-column weight FIFOs, all popped together.
// Column c output is delayed by c cycles so that the weights reach the systolic array
// as a diagonal wavefront.
// Optional debug taps (col_raw_o, level_o) are present when WFIFO_RAW_TAP_EN is defined.
module weight_skew_fifo_array #(
    parameter int unsigned NUM_COLS = 3,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush_i,
    input  logic [NUM_COLS-1:0]                    push_i,
    input  logic [NUM_COLS*DATA_W-1:0]             data_in_i,
    input  logic                                   pop_i,
    input  logic                                   err_clr_i,
    output logic                                   pop_ack_o,
    output logic [NUM_COLS*DATA_W-1:0]             col_out_o,
    output logic [NUM_COLS-1:0]                    col_valid_o,
    output logic [NUM_COLS-1:0]                    full_o,
    output logic [NUM_COLS-1:0]                    empty_o,
    output logic                                   overflow_err_o,
    output logic                                   underflow_err_o
`ifdef WFIFO_RAW_TAP_EN
    ,
    output logic [NUM_COLS*DATA_W-1:0]             col_raw_o,
    output logic [NUM_COLS*($clog2(DEPTH)+1)-1:0]  level_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0]   mem_q    [NUM_COLS][DEPTH];
    logic [AW-1:0]       wr_ptr_q [NUM_COLS];
    logic [AW-1:0]       wr_ptr_d [NUM_COLS];
    logic [AW-1:0]       rd_ptr_q [NUM_COLS];
    logic [AW-1:0]       rd_ptr_d [NUM_COLS];
    logic [CW-1:0]       count_q  [NUM_COLS];
    logic [CW-1:0]       count_d  [NUM_COLS];
    logic [DATA_W-1:0]   head     [NUM_COLS];
    logic [DATA_W-1:0]   launch   [NUM_COLS];
    logic [NUM_COLS-1:0] push_ok;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                ovf_set, unf_set;

    // Flags decode registered occupancy only; pop acceptance is all-or-nothing.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            full_o[c]  = (count_q[c] == CW'(DEPTH));
            empty_o[c] = (count_q[c] == '0);
        end
        pop_ack_o = pop_i & ~(|empty_o) & ~flush_i;
    end

    // Next-state for pointers, counts and sticky errors; flush wins over push/pop.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            head[c]     = mem_q[c][rd_ptr_q[c]];
            launch[c]   = pop_ack_o ? head[c] : '0;
            // A full queue still accepts a push when the same-cycle pop frees a slot.
            push_ok[c]  = push_i[c] & (~full_o[c] | pop_ack_o) & ~flush_i;
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (flush_i) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end else begin
                if (push_ok[c]) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                if (pop_ack_o)  rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                if (push_ok[c] && !pop_ack_o) begin
                    count_d[c] = count_q[c] + 1'b1;
                end else if (!push_ok[c] && pop_ack_o) begin
                    count_d[c] = count_q[c] - 1'b1;
                end
            end
        end
        ovf_set = ~flush_i & (|(push_i & ~push_ok));
        unf_set = ~flush_i & pop_i & (|empty_o);
        // Setting an error beats a same-cycle clear.
        ovf_d   = ovf_set ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
        unf_d   = unf_set ? 1'b1 : (err_clr_i ? 1'b0 : unf_q);
    end

    // Queue state and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage write; contents need no reset since counts gate every read.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_COLS; c++) begin
            if (push_ok[c]) mem_q[c][wr_ptr_q[c]] <= data_in_i[c*DATA_W +: DATA_W];
        end
    end

    assign overflow_err_o  = ovf_q;
    assign underflow_err_o = unf_q;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        if (c == 0) begin : g_direct
            assign col_out_o[c*DATA_W +: DATA_W] = launch[c];
            assign col_valid_o[c]                = pop_ack_o;
        end else begin : g_skew
            logic [DATA_W-1:0] pipe_d_q [c];
            logic              pipe_v_q [c];

            // c-stage delay line, free-running so bubbles travel as zero/invalid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) begin
                        pipe_d_q[i] <= '0;
                        pipe_v_q[i] <= 1'b0;
                    end
                end else if (flush_i) begin
                    for (int i = 0; i < c; i++) begin
                        pipe_d_q[i] <= '0;
                        pipe_v_q[i] <= 1'b0;
                    end
                end else begin
                    pipe_d_q[0] <= launch[c];
                    pipe_v_q[0] <= pop_ack_o;
                    for (int i = 1; i < c; i++) begin
                        pipe_d_q[i] <= pipe_d_q[i-1];
                        pipe_v_q[i] <= pipe_v_q[i-1];
                    end
                end
            end

            assign col_out_o[c*DATA_W +: DATA_W] = pipe_d_q[c-1];
            assign col_valid_o[c]                = pipe_v_q[c-1];
        end

`ifdef WFIFO_RAW_TAP_EN
        assign col_raw_o[c*DATA_W +: DATA_W] = head[c];
        assign level_o[c*CW +: CW]           = count_q[c];
`endif
    end

endmodule

// File: tb/tb_weight_skew_fifo_array.sv
// Self-checking bench for weight_skew_fifo_array: directed scenarios plus random traffic,
// compared against a queue-based model with an explicit per-column delay history.
module tb_weight_skew_fifo_array;

    localparam int N = 3;
    localparam int W = 8;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush_i;
    logic [N-1:0]   push_i;
    logic [N*W-1:0] data_in_i;
    logic           pop_i;
    logic           err_clr_i;
    logic           pop_ack_o;
    logic [N*W-1:0] col_out_o;
    logic [N-1:0]   col_valid_o;
    logic [N-1:0]   full_o;
    logic [N-1:0]   empty_o;
    logic           overflow_err_o;
    logic           underflow_err_o;

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per column, launch history indexed by age in cycles.
    logic [W-1:0]   mq [N][$];
    logic [N*W-1:0] hd [N];
    logic           hv [N];
    logic           m_ovf, m_unf;

    always #5 clk = ~clk;

    weight_skew_fifo_array #(
        .NUM_COLS (N),
        .DATA_W   (W),
        .DEPTH    (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .push_i          (push_i),
        .data_in_i       (data_in_i),
        .pop_i           (pop_i),
        .err_clr_i       (err_clr_i),
        .pop_ack_o       (pop_ack_o),
        .col_out_o       (col_out_o),
        .col_valid_o     (col_valid_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .overflow_err_o  (overflow_err_o),
        .underflow_err_o (underflow_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) mq[c].delete();
        for (int k = 0; k < N; k++) begin
            hd[k] = '0;
            hv[k] = 1'b0;
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [N*W-1:0] vals(input int base);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = W'(c*16 + base);
        return v;
    endfunction

    // One clock cycle: drive, check combinational/registered outputs, advance the model.
    task automatic step(input logic [N-1:0] p, input logic [N*W-1:0] d, input logic pp,
                        input logic fl, input logic ec);
        logic           anyempty, ack, ovs, uns;
        logic [N*W-1:0] lv, eo;
        logic [N-1:0]   ev, ef, ee;
        @(negedge clk);
        push_i = p; data_in_i = d; pop_i = pp; flush_i = fl; err_clr_i = ec;
        #1;
        anyempty = 1'b0;
        for (int c = 0; c < N; c++) if (mq[c].size() == 0) anyempty = 1'b1;
        ack = pp && !fl && !anyempty;
        for (int c = 0; c < N; c++) begin
            lv[c*W +: W] = ack ? mq[c][0] : '0;
            ef[c] = (mq[c].size() == D);
            ee[c] = (mq[c].size() == 0);
            if (c == 0) begin
                eo[c*W +: W] = lv[c*W +: W];
                ev[c]        = ack;
            end else begin
                eo[c*W +: W] = hd[c][c*W +: W];
                ev[c]        = hv[c];
            end
        end
        chk("pop_ack", 64'(pop_ack_o), 64'(ack));
        chk("col_out", 64'(col_out_o), 64'(eo));
        chk("col_valid", 64'(col_valid_o), 64'(ev));
        chk("full", 64'(full_o), 64'(ef));
        chk("empty", 64'(empty_o), 64'(ee));
        chk("overflow_err", 64'(overflow_err_o), 64'(m_ovf));
        chk("underflow_err", 64'(underflow_err_o), 64'(m_unf));
        ovs = 1'b0;
        uns = 1'b0;
        if (fl) begin
            for (int c = 0; c < N; c++) mq[c].delete();
            for (int k = 0; k < N; k++) begin
                hd[k] = '0;
                hv[k] = 1'b0;
            end
        end else begin
            uns = pp && anyempty;
            if (ack) for (int c = 0; c < N; c++) void'(mq[c].pop_front());
            for (int c = 0; c < N; c++) begin
                if (p[c]) begin
                    if (mq[c].size() < D) mq[c].push_back(d[c*W +: W]);
                    else ovs = 1'b1;
                end
            end
            for (int k = N - 1; k >= 2; k--) begin
                hd[k] = hd[k-1];
                hv[k] = hv[k-1];
            end
            hd[1] = lv;
            hv[1] = ack;
        end
        m_ovf = ovs ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_unf = uns ? 1'b1 : (ec ? 1'b0 : m_unf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N*W-1:0] rd;
        rst_n = 1'b0; flush_i = 1'b0; push_i = '0; data_in_i = '0; pop_i = 1'b0; err_clr_i = 1'b0;
        model_reset();
        #12;
        chk("rst_col_out", 64'(col_out_o), 64'(0));
        chk("rst_col_valid", 64'(col_valid_o), 64'(0));
        chk("rst_empty", 64'(empty_o), 64'(3'b111));
        chk("rst_full", 64'(full_o), 64'(0));
        chk("rst_errors", 64'({overflow_err_o, underflow_err_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill/drain with the wavefront values checked explicitly.
        for (int i = 1; i <= D; i++) step('1, vals(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step('0, '0, (k < 4), 1'b0, 1'b0);
            if (k < 4) chk("drain_col0", 64'(col_out_o[0 +: W]), 64'(k + 1));
            if (k >= 1 && k <= 4) chk("drain_col1", 64'(col_out_o[W +: W]), 64'(16 + k));
            if (k >= 2) chk("drain_col2", 64'(col_out_o[2*W +: W]), 64'(32 + k - 1));
            chk("drain_valid", 64'(col_valid_o),
                64'({(k >= 2), (k >= 1 && k <= 4), (k < 4)}));
        end

        // Overflow on column 1; cols 0/2 filled so the drain can proceed.
        for (int i = 1; i <= 5; i++) step((i <= D) ? 3'b111 : 3'b010, vals(i + 4), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < D + 2; i++) step('0, '0, (i < D), 1'b0, 1'b0);
        chk("ovf_sticky", 64'(overflow_err_o), 64'(1));
        step('0, '0, 1'b0, 1'b0, 1'b1);

        // Full queues with simultaneous push and pop.
        for (int i = 1; i <= D; i++) step('1, vals(i + 8), 1'b0, 1'b0, 1'b0);
        step(3'b001, vals(15), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < D + 2; i++) step('0, '0, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b1);

        // Lock-step underflow with one empty column.
        step(3'b011, vals(1), 1'b0, 1'b0, 1'b0);
        step(3'b011, vals(2), 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1, 1'b0);

        // Pointer wrap with one entry in flight.
        for (int r = 0; r < 10; r++) begin
            step('1, vals(r + 3), 1'b0, 1'b0, 1'b0);
            step('0, '0, 1'b1, 1'b0, 1'b0);
        end
        idle(3);

        // Flush while popping with the skew pipes loaded; set an error first to see it held.
        step('0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= D; i++) step('1, vals(i), 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        step('1, vals(9), 1'b1, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_valid", 64'(col_valid_o), 64'(0));
        chk("flush_unf_held", 64'(underflow_err_o), 64'(1));
        step('0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            logic fl, ec;
            fl = ($urandom_range(0, 39) == 0);
            ec = !fl && ($urandom_range(0, 19) == 0);
            rd = N*W'($urandom);
            step(N'($urandom_range(0, 7)), rd, 1'($urandom_range(0, 1)), fl, ec);
        end

        // Asynchronous reset in the middle of a transfer.
        for (int i = 1; i <= D; i++) step('1, vals(i), 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        pop_i = 1'b1; push_i = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_col_out", 64'(col_out_o), 64'(0));
        chk("arst_col_valid", 64'(col_valid_o), 64'(0));
        chk("arst_pop_ack", 64'(pop_ack_o), 64'(0));
        chk("arst_empty", 64'(empty_o), 64'(3'b111));
        chk("arst_full", 64'(full_o), 64'(0));
        model_reset();
        @(negedge clk);
        pop_i = 1'b0;
        rst_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
